// File: rtl/uart_rx_engine_pkg.sv
// Shared constants for the UART receive engine: FSM encodings, frame bit counts
// and the helper that turns the live configuration into a bit count.
package uart_rx_engine_pkg;

  localparam int K_WIDTH_DEF = 19;
  localparam int DATA7       = 7;
  localparam int DATA8       = 8;
  localparam int MAX_RX_BITS = 10;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] START   = 2'd1;
  localparam logic [1:0] RECEIVE = 2'd2;

  // Bits sampled after the start bit, stop bit included (8..10).
  function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
    return 4'd1 + (eight ? 4'(DATA8) : 4'(DATA7)) + {3'b000, pen};
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-time counter for the receiver: free-runs while not cleared and flags the
// half-bit and full-bit points relative to the clocks-per-bit value k.
module uart_rx_bit_timer #(
  parameter int K_WIDTH = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [K_WIDTH-1:0] k,
  output logic               half_btu,
  output logic               btu
);

  localparam logic [K_WIDTH-1:0] ONE = K_WIDTH'(1);

  logic [K_WIDTH-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timer <= '0;
    else if (clr)
      timer <= '0;
    else
      timer <= timer + ONE;
  end

  // Greater-or-equal so a k lowered mid-frame still ends the bit instead of wrapping.
  assign half_btu = (timer >= (k >> 1));
  assign btu      = (timer >= (k - ONE));

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive core: synchronizes RX, validates the start bit, samples each bit
// at mid-bit time LSB first and posts data plus parity/framing/overrun status.
module uart_rx_engine
  import uart_rx_engine_pkg::*;
#(
  parameter int K_WIDTH     = K_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               RX,
  input  logic [K_WIDTH-1:0] k,
  input  logic               EIGHT,
  input  logic               PEN,
  input  logic               OHEL,
  input  logic               Read,
  output logic [7:0]         RxData,
  output logic               RxRdy,
  output logic               PERR,
  output logic               FERR,
  output logic               OVF
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [3:0]             bitcnt;
  logic [3:0]             bitcnt_nxt;
  logic [3:0]             n_bits;
  logic [MAX_RX_BITS-1:0] sr;
  logic [MAX_RX_BITS-1:0] sr_nxt;
  logic [MAX_RX_BITS-1:0] frame_j;
  logic [7:0]             data_w;
  logic                   par_w;
  logic                   stop_w;
  logic                   half_btu;
  logic                   btu;
  logic                   timer_clr;
  logic                   sample;
  logic                   done;
  logic                   sr_spill_unused;

  // Synchronizer resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      sync <= '1;
    else
      sync <= {sync[SYNC_STAGES-2:0], RX};
  end

  assign rx_s = sync[SYNC_STAGES-1];

  uart_rx_bit_timer #(
    .K_WIDTH (K_WIDTH)
  ) u_timer (
    .clk      (Clk),
    .rst_n    (Rst),
    .clr      (timer_clr),
    .k        (k),
    .half_btu (half_btu),
    .btu      (btu)
  );

  assign n_bits     = frame_bits(EIGHT, PEN);
  assign sample     = (state == RECEIVE) && btu;
  assign bitcnt_nxt = bitcnt + 4'd1;
  assign done       = sample && (bitcnt_nxt >= n_bits);
  assign timer_clr  = ((state != START) && (state != RECEIVE)) ||
                      ((state == START) && half_btu) || sample;

  // The final sample is merged combinationally so completion lands on the same edge.
  assign sr_nxt  = {rx_s, sr[MAX_RX_BITS-1:1]};
  assign frame_j = sr_nxt >> (4'(MAX_RX_BITS) - n_bits);
  assign data_w  = EIGHT ? frame_j[7:0] : {1'b0, frame_j[6:0]};
  assign par_w   = EIGHT ? frame_j[8] : frame_j[7];
  assign stop_w  = frame_j[n_bits - 4'd1];
  assign sr_spill_unused = sr[0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (half_btu) state_nxt = rx_s ? IDLE : RECEIVE;
      RECEIVE: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      sr     <= '0;
    end else begin
      state <= state_nxt;
      if (state != RECEIVE)
        bitcnt <= '0;
      else if (sample)
        bitcnt <= done ? 4'd0 : bitcnt_nxt;
      if (sample)
        sr <= sr_nxt;
    end
  end

  // A completion on the same edge as Read wins; OVF then starts clean.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RxData <= '0;
      RxRdy  <= 1'b0;
      PERR   <= 1'b0;
      FERR   <= 1'b0;
      OVF    <= 1'b0;
    end else if (done) begin
      RxData <= data_w;
      RxRdy  <= 1'b1;
      FERR   <= ~stop_w;
      PERR   <= PEN && ((^{data_w, par_w}) != OHEL);
      OVF    <= RxRdy && !Read;
    end else if (Read) begin
      RxRdy <= 1'b0;
      PERR  <= 1'b0;
      FERR  <= 1'b0;
      OVF   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine at k=16: frames are driven on the falling
// clock edge with exact 16-clock bit times and outputs are checked on falling edges.
module tb_uart_rx_engine;
  import uart_rx_engine_pkg::*;

  localparam int KW = 19;

  logic          Clk   = 1'b0;
  logic          Rst   = 1'b0;
  logic          RX    = 1'b1;
  logic [KW-1:0] k     = 19'd16;
  logic          EIGHT = 1'b1;
  logic          PEN   = 1'b0;
  logic          OHEL  = 1'b0;
  logic          Read  = 1'b0;
  logic [7:0]    RxData;
  logic          RxRdy;
  logic          PERR;
  logic          FERR;
  logic          OVF;

  int checks = 0;
  int errors = 0;

  uart_rx_engine #(
    .K_WIDTH     (KW),
    .SYNC_STAGES (2)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .RX     (RX),
    .k      (k),
    .EIGHT  (EIGHT),
    .PEN    (PEN),
    .OHEL   (OHEL),
    .Read   (Read),
    .RxData (RxData),
    .RxRdy  (RxRdy),
    .PERR   (PERR),
    .FERR   (FERR),
    .OVF    (OVF)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    RX = b;
    repeat (16) @(negedge Clk);
  endtask

  // Stop bit is driven 16 clocks; rd pulses Read on the completion edge,
  // lat checks RxRdy just before and just after that edge.
  task automatic send_frame(input logic [7:0] d, input int nd, input logic pen,
                            input logic par, input logic stop, input logic rd,
                            input logic lat);
    bit_time(1'b0);
    for (int i = 0; i < nd; i++) bit_time(d[i]);
    if (pen) bit_time(par);
    RX = stop;
    for (int i = 0; i < 16; i++) begin
      Read = rd && (i == 11);
      if (lat && i == 11) check("rdy_before_stop_sample", RxRdy, 0);
      if (lat && i == 12) check("rdy_after_stop_sample", RxRdy, 1);
      @(negedge Clk);
    end
    Read = 1'b0;
    RX   = 1'b1;
  endtask

  task automatic do_read();
    Read = 1'b1;
    @(negedge Clk);
    Read = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    logic [7:0] v;

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_data", RxData, 0);
    check("rst_rdy", RxRdy, 0);
    check("rst_perr", PERR, 0);
    check("rst_ferr", FERR, 0);
    check("rst_ovf", OVF, 0);
    check("rst_state", dut.state, IDLE);
    Rst = 1'b1;
    repeat (5) @(negedge Clk);

    // 8N1 0xA5
    EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("a5_data", RxData, 8'hA5);
    check("a5_perr", PERR, 0);
    check("a5_ferr", FERR, 0);
    check("a5_ovf", OVF, 0);
    do_read();
    check("a5_read_rdy", RxRdy, 0);
    check("a5_read_data", RxData, 8'hA5);

    // 7E1 0x41, good parity then bad parity
    EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b0;
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("7e1_data", RxData, 8'h41);
    check("7e1_rdy", RxRdy, 1);
    check("7e1_perr_ok", PERR, 0);
    do_read();
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("7e1_bad_data", RxData, 8'h41);
    check("7e1_perr_bad", PERR, 1);
    do_read();
    check("7e1_read_perr", PERR, 0);

    // 7-bit mode forces bit 7 low even if the line carries a 1 there
    PEN = 1'b0;
    send_frame(8'h7F, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("7n1_data", RxData, 8'h7F);
    do_read();

    // 8O1 0x00, stop bit low
    EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b1;
    send_frame(8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("8o1_data", RxData, 8'h00);
    check("8o1_ferr", FERR, 1);
    check("8o1_perr", PERR, 0);
    check("8o1_rdy", RxRdy, 1);
    repeat (40) @(negedge Clk);
    check("8o1_idle", dut.state, IDLE);
    do_read();
    check("8o1_read_ferr", FERR, 0);

    // 4-clock glitch is rejected, following frame is clean
    EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
    RX = 1'b0;
    repeat (4) @(negedge Clk);
    RX = 1'b1;
    repeat (30) @(negedge Clk);
    check("glitch_rdy", RxRdy, 0);
    check("glitch_state", dut.state, IDLE);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("3c_data", RxData, 8'h3C);
    check("3c_rdy", RxRdy, 1);
    check("3c_ferr", FERR, 0);
    do_read();

    // Back-to-back frames without Read -> overrun
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("b2b_data", RxData, 8'h22);
    check("b2b_rdy", RxRdy, 1);
    check("b2b_ovf", OVF, 1);
    do_read();
    check("b2b_read_ovf", OVF, 0);
    check("b2b_read_rdy", RxRdy, 0);

    // Read on the completion edge of the second frame: completion wins, no overrun
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("rdcmp_ovf", OVF, 0);
    check("rdcmp_rdy", RxRdy, 1);
    check("rdcmp_data", RxData, 8'h22);

    // Reset during bit 4 aborts the frame
    v = 8'h5A;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(v[i]);
    RX = v[4];
    repeat (8) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("midrst_data", RxData, 0);
    check("midrst_rdy", RxRdy, 0);
    check("midrst_perr", PERR, 0);
    check("midrst_ferr", FERR, 0);
    check("midrst_ovf", OVF, 0);
    check("midrst_state", dut.state, IDLE);
    RX = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    repeat (20) @(negedge Clk);
    check("postrst_rdy", RxRdy, 0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("5a_data", RxData, 8'h5A);
    check("5a_rdy", RxRdy, 1);
    check("5a_perr", PERR, 0);
    check("5a_ferr", FERR, 0);
    check("5a_ovf", OVF, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
